// File: rtl/memctrl_arbiter.sv
// memctrl_arbiter: two-port arbiter and access sequencer in front of the
// BISR memory controller. Each granted request becomes a fixed two-cycle
// access: one ACCESS cycle with strobes active, then one RECOVER cycle with
// strobes idle, during which read data is captured. BIST can take over the
// controller, but only once any in-flight access has finished.
//
// Build option: define MEMARB_FIXED_PRIO_EN for fixed priority, where port 0
// always beats port 1. Leave it undefined (the default) for round-robin.
//
// Every output comes straight from a register. The next-state logic
// computes the value each output will hold in the following cycle.
module memctrl_arbiter #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic [DW-1:0] RDATA,
    output logic          RVALID,
    output logic          RID,
    input  logic          BIST_REQ,
    input  logic [2:0]    BIST_MODE_IN,
    output logic          BIST_ACK,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_IDATA,
    output logic          MEM_CE,
    output logic          MEM_CSB,
    output logic          MEM_OEB,
    output logic          MEM_WEB,
    input  logic [DW-1:0] MEM_ODATA,
    output logic          MEM_BIST_EN,
    output logic [2:0]    MEM_BIST_MODE
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RECOVER = 2'd2,
        S_BIST    = 2'd3
    } state_t;

    state_t        r_state, w_state_next;

    logic          r_gnt0, w_gnt0_next;
    logic          r_gnt1, w_gnt1_next;
    logic [AW-1:0] r_mem_addr, w_mem_addr_next;
    logic [DW-1:0] r_mem_idata, w_mem_idata_next;
    logic          r_mem_ce, w_mem_ce_next;
    logic          r_mem_csb, w_mem_csb_next;
    logic          r_mem_oeb, w_mem_oeb_next;
    logic          r_mem_web, w_mem_web_next;
    logic [DW-1:0] r_rdata, w_rdata_next;
    logic          r_rvalid, w_rvalid_next;
    logic          r_rid, w_rid_next;
    logic          r_bist_en, w_bist_en_next;
    logic [2:0]    r_bist_mode, w_bist_mode_next;

    // Attributes of the access in flight. RECOVER uses them to return read data.
    logic          r_acc_read, w_acc_read_next;
    logic          r_acc_id, w_acc_id_next;

    // Arbitration winner for the current decision (0 = port 0, 1 = port 1)
    logic          w_winner;
    logic          w_any_req;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_any_req = REQ0 | REQ1;

`ifdef MEMARB_FIXED_PRIO_EN
    // Port 0 always wins when it is requesting
    assign w_winner = ~REQ0;
`else
    logic r_last;

    // On a tie the port not granted last wins. A lone requester always wins.
    assign w_winner = (REQ0 && REQ1) ? ~r_last : REQ1;

    // Track the most recently granted port. It resets to port 1, so port 0
    // wins the first tie.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last <= 1'b1;
        end else if (w_gnt0_next || w_gnt1_next) begin
            r_last <= w_gnt1_next;
        end
    end
`endif

    assign w_sel_we    = w_winner ? WE1    : WE0;
    assign w_sel_addr  = w_winner ? ADDR1  : ADDR0;
    assign w_sel_wdata = w_winner ? WDATA1 : WDATA0;

    // Next state plus the next value of every registered output
    always_comb begin
        w_state_next     = r_state;
        w_gnt0_next      = 1'b0;
        w_gnt1_next      = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_idata_next = '0;
        w_mem_ce_next    = 1'b0;
        w_mem_csb_next   = 1'b1;
        w_mem_oeb_next   = 1'b1;
        w_mem_web_next   = 1'b1;
        w_rdata_next     = r_rdata;
        w_rvalid_next    = 1'b0;
        w_rid_next       = r_rid;
        w_bist_en_next   = 1'b0;
        w_bist_mode_next = 3'd0;
        w_acc_read_next  = r_acc_read;
        w_acc_id_next    = r_acc_id;

        case (r_state)
            S_IDLE, S_RECOVER: begin
                // The read finishing in RECOVER is returned even when BIST
                // takes over next
                if (r_state == S_RECOVER && r_acc_read) begin
                    w_rvalid_next = 1'b1;
                    w_rdata_next  = MEM_ODATA;
                    w_rid_next    = r_acc_id;
                end

                // Decision point: BIST first, then the arbitration winner
                if (BIST_REQ) begin
                    w_state_next     = S_BIST;
                    w_bist_en_next   = 1'b1;
                    w_bist_mode_next = BIST_MODE_IN;
                end else if (w_any_req) begin
                    w_state_next     = S_ACCESS;
                    w_gnt0_next      = ~w_winner;
                    w_gnt1_next      = w_winner;
                    w_mem_addr_next  = w_sel_addr;
                    w_mem_idata_next = w_sel_wdata;
                    w_mem_ce_next    = 1'b1;
                    w_mem_csb_next   = 1'b0;
                    w_mem_web_next   = ~w_sel_we;
                    w_mem_oeb_next   = w_sel_we;
                    w_acc_read_next  = ~w_sel_we;
                    w_acc_id_next    = w_winner;
                end else begin
                    w_state_next = S_IDLE;
                end
            end

            S_ACCESS: begin
                // Always followed by RECOVER. The default strobe values
                // above are the inactive ones.
                w_state_next = S_RECOVER;
            end

            S_BIST: begin
                if (BIST_REQ) begin
                    w_bist_en_next   = 1'b1;
                    w_bist_mode_next = r_bist_mode;
                end else begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_idata <= '0;
            r_mem_ce    <= 1'b0;
            r_mem_csb   <= 1'b1;
            r_mem_oeb   <= 1'b1;
            r_mem_web   <= 1'b1;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_rid       <= 1'b0;
            r_bist_en   <= 1'b0;
            r_bist_mode <= 3'd0;
            r_acc_read  <= 1'b0;
            r_acc_id    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_gnt0      <= w_gnt0_next;
            r_gnt1      <= w_gnt1_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_idata <= w_mem_idata_next;
            r_mem_ce    <= w_mem_ce_next;
            r_mem_csb   <= w_mem_csb_next;
            r_mem_oeb   <= w_mem_oeb_next;
            r_mem_web   <= w_mem_web_next;
            r_rdata     <= w_rdata_next;
            r_rvalid    <= w_rvalid_next;
            r_rid       <= w_rid_next;
            r_bist_en   <= w_bist_en_next;
            r_bist_mode <= w_bist_mode_next;
            r_acc_read  <= w_acc_read_next;
            r_acc_id    <= w_acc_id_next;
        end
    end

    assign GNT0          = r_gnt0;
    assign GNT1          = r_gnt1;
    assign RDATA         = r_rdata;
    assign RVALID        = r_rvalid;
    assign RID           = r_rid;
    assign BIST_ACK      = r_bist_en;
    assign MEM_BIST_EN   = r_bist_en;
    assign MEM_BIST_MODE = r_bist_mode;
    assign MEM_ADDR      = r_mem_addr;
    assign MEM_IDATA     = r_mem_idata;
    assign MEM_CE        = r_mem_ce;
    assign MEM_CSB       = r_mem_csb;
    assign MEM_OEB       = r_mem_oeb;
    assign MEM_WEB       = r_mem_web;

endmodule

// File: doc/memctrl_arbiter.md
# memctrl_arbiter

Two-port round-robin arbiter and access sequencer in front of the BISR-equipped memory controller. It accepts read/write requests from two independent requesters, drives the controller's SRAM strobe interface (CE/CSB/WEB/OEB, address, write data) with a fixed 2-cycle access shape, and returns read data with a valid pulse and port ID. It also hands the controller over to BIST on request, draining any in-flight access first.

## Interface
- `AW`, default 16: address width.
- `DW`, default 8: data width.

Ports:
- `CLK` in 1: clock; all logic on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `REQ0`, `REQ1` in 1: access request, port 0 / port 1.
- `WE0`, `WE1` in 1: 1 = write, 0 = read.
- `ADDR0`, `ADDR1` in AW: request address.
- `WDATA0`, `WDATA1` in DW: write data.
- `GNT0`, `GNT1` out 1: one-cycle grant pulse.
- `RDATA` out DW: read data.
- `RVALID` out 1: one-cycle pulse marking valid `RDATA`.
- `RID` out 1: port that issued the returned read.
- `BIST_REQ` in 1: BIST ownership request, level.
- `BIST_MODE_IN` in 3: BIST mode to apply.
- `BIST_ACK` out 1: arbiter has released the memory to BIST.
- `MEM_ADDR` out AW, `MEM_IDATA` out DW: to controller `ADDR` / `IDATA`.
- `MEM_CE`, `MEM_CSB`, `MEM_OEB`, `MEM_WEB` out 1: controller strobes.
- `MEM_ODATA` in DW: controller `ODATA`.
- `MEM_BIST_EN` out 1, `MEM_BIST_MODE` out 3: to controller.

## Operation
- States: IDLE, ACCESS, RECOVER, BIST.
- **Decision point.** IDLE, or the last cycle of RECOVER, when the next state is chosen:
  - `BIST_REQ`=1 → BIST. BIST has priority over both ports.
  - Otherwise any `REQx` → ACCESS with the arbitration winner.
  - Otherwise → IDLE.
- **Round-robin arbitration.**
  - If only one port requests, that port wins.
  - If both request, the winner is the port not granted last.
  - The last-granted pointer resets to port 1, so port 0 wins the first tie.
- **ACCESS (1 cycle).**
  - `MEM_CE`=1, `MEM_CSB`=0.
  - `MEM_ADDR`/`MEM_IDATA` hold the winner's `ADDRx`/`WDATAx`.
  - Write: `MEM_WEB`=0, `MEM_OEB`=1. Read: `MEM_WEB`=1, `MEM_OEB`=0.
  - `GNTx` pulses high for this cycle.
  - The requester must hold `REQx`/`WEx`/`ADDRx`/`WDATAx` stable until it sees `GNTx`. It may drop or change them the cycle after.
- **RECOVER (1 cycle).**
  - `MEM_CE`=0, `MEM_CSB`=1, `MEM_OEB`=1, `MEM_WEB`=1.
  - `MEM_ADDR` holds its value; `MEM_IDATA`=0.
  - For a read, `MEM_ODATA` is sampled at the end of this cycle. `RDATA`/`RID` are loaded and `RVALID` pulses in the following cycle.
- **BIST.**
  - On entry, `MEM_BIST_MODE` latches `BIST_MODE_IN`; `MEM_BIST_EN`=1 and `BIST_ACK`=1.
  - All strobes are inactive and no grants are issued.
  - Exit to IDLE on the cycle after `BIST_REQ` is sampled 0. `MEM_BIST_EN`, `BIST_ACK` and `MEM_BIST_MODE` return to 0.
- **Boundary conditions.**
  - `BIST_REQ` rising during ACCESS: the access completes through RECOVER, then BIST is entered. Read data is still returned.
  - A requester that drops `REQx` before its grant loses its slot with no side effect.
  - A request arriving in ACCESS is considered at the next decision point.
- **Reset values.** Applied on the edge where `RST`=1, including mid-access: the strobe is aborted and no `RVALID` is produced for it.
  - State = IDLE.
  - `MEM_CE`=0, `MEM_CSB`=1, `MEM_OEB`=1, `MEM_WEB`=1.
  - `MEM_ADDR`=0, `MEM_IDATA`=0.
  - `GNT0`=`GNT1`=0.
  - `RDATA`=0, `RVALID`=0, `RID`=0.
  - `BIST_ACK`=0, `MEM_BIST_EN`=0, `MEM_BIST_MODE`=0.

## Timing
- All outputs are registered.
- Request sampled at edge N → ACCESS (strobes and `GNTx`) in cycle N+1 → RECOVER in N+2 → `RVALID` in N+3.
- Back-to-back throughput is 1 access per 2 cycles: RECOVER → ACCESS with no IDLE between.
- `BIST_REQ` sampled high in IDLE → `MEM_BIST_EN`/`BIST_ACK` high the next cycle.
- `BIST_REQ` sampled high in ACCESS → `MEM_BIST_EN` high 2 cycles later.
- `RVALID` for access k can coincide with ACCESS of access k+1.

## Configuration
- `MEMARB_FIXED_PRIO_EN`
  - Defined: fixed priority, port 0 always beats port 1. The last-granted pointer is not implemented.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then port 0 writes 0xA5 to 0x1234 → ACCESS cycle shows `MEM_ADDR`=0x1234, `MEM_IDATA`=0xA5, `MEM_WEB`=0, `MEM_CSB`=0, `GNT0`=1; the next cycle shows all strobes inactive.
- Port 1 reads 0x1234 with the model returning 0xA5 → `RVALID`=1, `RDATA`=0xA5, `RID`=1, three cycles after the request is sampled.
- Both ports request continuously for 8 accesses → grants alternate 0,1,0,1,… with one ACCESS every 2 cycles. With `MEMARB_FIXED_PRIO_EN` defined, all 8 go to port 0.
- `BIST_REQ`=1 with `BIST_MODE_IN`=3'b010 asserted during a port 0 read ACCESS → the read completes with `RVALID`; `MEM_BIST_EN`=1, `MEM_BIST_MODE`=3'b010 two cycles later; no `GNTx` while `BIST_REQ` is high; IDLE resumes one cycle after it drops.
- `RST` asserted during ACCESS → next cycle `MEM_CSB`=1, `MEM_CE`=0, no `RVALID`; the first tie after reset grants port 0.
